// File: rtl/wb_epbuf_dma.sv
// Wishbone word-copy DMA between a memory slave and the USB EP-buffer bridge.
// CPU programs addresses and length over a 4-word CSR window and waits for done_stb.
module wb_epbuf_dma #(
  parameter int EW = 9,
  parameter int MW = 15,
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    csr_addr,
  output logic [31:0]   csr_rdata,
  input  logic [31:0]   csr_wdata,
  input  logic          csr_we,
  input  logic          csr_cyc,
  output logic          csr_ack,
  output logic [EW-1:0] ep_addr,
  input  logic [31:0]   ep_rdata,
  output logic [31:0]   ep_wdata,
  output logic          ep_we,
  output logic          ep_cyc,
  input  logic          ep_ack,
  output logic [MW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  output logic          mem_cyc,
  input  logic          mem_ack,
  output logic          done_stb
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] ep_addr_q, ep_addr_d;
  logic [MW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   data_q, data_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic          abrt_q, abrt_d;
  logic          pend_q, pend_d;
  logic          csr_ack_q;
  logic [31:0]   csr_rdata_q;
  logic [31:0]   rd_mux;

  logic busy, csr_wr, ctrl_wr, src_ack, dst_ack, last;
  logic unused_ok;

  assign busy    = (state_q != IDLE);
  assign csr_wr  = csr_cyc & csr_we & csr_ack_q;
  assign ctrl_wr = csr_wr & (csr_addr == 2'd0);
  assign src_ack = dir_q ? ep_ack : mem_ack;
  assign dst_ack = dir_q ? mem_ack : ep_ack;
  assign last    = (cnt_q == '0) | pend_q;
  assign unused_ok = ^csr_wdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ep_addr_d  = ep_addr_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    dir_d      = dir_q;
    done_d     = done_q;
    abrt_d     = abrt_q;
    done_stb   = 1'b0;
    // Abort only latches while busy; the word in flight still finishes.
    pend_d     = pend_q | (busy & ctrl_wr & csr_wdata[13]);
    case (state_q)
      IDLE: begin
        if (csr_wr) begin
          case (csr_addr)
            2'd0: if (csr_wdata[15]) begin
              cnt_d   = csr_wdata[LW-1:0];
              dir_d   = csr_wdata[14];
              done_d  = 1'b0;
              abrt_d  = 1'b0;
              pend_d  = 1'b0;
              state_d = RD;
            end
            2'd1:    ep_addr_d  = csr_wdata[EW-1:0];
            2'd2:    mem_addr_d = csr_wdata[MW-1:0];
            default: ;
          endcase
        end
      end
      RD: begin
        if (src_ack) begin
          data_d  = dir_q ? ep_rdata : mem_rdata;
          state_d = WR;
        end
      end
      WR: begin
        if (dst_ack) begin
          ep_addr_d  = ep_addr_q + EW'(1);
          mem_addr_d = mem_addr_q + MW'(1);
          if (last) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            abrt_d   = pend_q;
            pend_d   = 1'b0;
            done_stb = 1'b1;
          end else begin
            cnt_d   = cnt_q - LW'(1);
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      2'd0: begin
        rd_mux[31] = busy;
        rd_mux[30] = done_q;
        rd_mux[29] = abrt_q;
        rd_mux[14] = dir_q;
        rd_mux[LW:0] = busy ? ({1'b0, cnt_q} + (LW+1)'(1)) : '0;
      end
      2'd1:    rd_mux[EW-1:0] = ep_addr_q;
      2'd2:    rd_mux[MW-1:0] = mem_addr_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ep_addr_q   <= '0;
      mem_addr_q  <= '0;
      data_q      <= '0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      abrt_q      <= 1'b0;
      pend_q      <= 1'b0;
      csr_ack_q   <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ep_addr_q   <= ep_addr_d;
      mem_addr_q  <= mem_addr_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      abrt_q      <= abrt_d;
      pend_q      <= pend_d;
      csr_ack_q   <= csr_cyc & ~csr_ack_q;
      // Read data is only non-zero in the ack cycle.
      csr_rdata_q <= (csr_cyc & ~csr_ack_q) ? rd_mux : '0;
    end
  end

  assign csr_ack   = csr_ack_q;
  assign csr_rdata = csr_rdata_q;

  // Bus strobes come from registered state only, so an ack drops cyc next cycle.
  assign mem_cyc   = ((state_q == RD) & ~dir_q) | ((state_q == WR) & dir_q);
  assign ep_cyc    = ((state_q == RD) & dir_q) | ((state_q == WR) & ~dir_q);
  assign mem_we    = (state_q == WR) & dir_q;
  assign ep_we     = (state_q == WR) & ~dir_q;
  assign ep_addr   = ep_addr_q;
  assign mem_addr  = mem_addr_q;
  assign ep_wdata  = data_q;
  assign mem_wdata = data_q;

endmodule

// File: tb/tb_wb_epbuf_dma.sv
// Bench for wb_epbuf_dma: delay-configurable Wishbone slave models, CSR table,
// directed corner sequences and random transfers checked against an array copy model.
module tb_wb_epbuf_dma;
  localparam int EW = 9, MW = 15, LW = 9;
  localparam int EN = 1 << EW, MN = 1 << MW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    csr_addr;
  logic [31:0]   csr_rdata, csr_wdata;
  logic          csr_we, csr_cyc, csr_ack;
  logic [EW-1:0] ep_addr;
  logic [31:0]   ep_rdata, ep_wdata;
  logic          ep_we, ep_cyc, ep_ack;
  logic [MW-1:0] mem_addr;
  logic [31:0]   mem_rdata, mem_wdata;
  logic          mem_we, mem_cyc, mem_ack;
  logic          done_stb;

  wb_epbuf_dma #(.EW(EW), .MW(MW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_wdata(csr_wdata),
    .csr_we(csr_we), .csr_cyc(csr_cyc), .csr_ack(csr_ack),
    .ep_addr(ep_addr), .ep_rdata(ep_rdata), .ep_wdata(ep_wdata),
    .ep_we(ep_we), .ep_cyc(ep_cyc), .ep_ack(ep_ack),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_cyc(mem_cyc), .mem_ack(mem_ack),
    .done_stb(done_stb)
  );

  // Slave models: ack arrives dly cycles after the first cycle beyond cyc rising.
  logic [31:0]   mem_arr [0:MN-1];
  logic [31:0]   ep_arr  [0:EN-1];
  logic [31:0]   mdl_mem [0:MN-1];
  logic [31:0]   mdl_ep  [0:EN-1];
  logic [EW-1:0] ep_rd_log [0:4095];
  int mem_dly = 0, ep_dly = 0, mem_wait = 0, ep_wait = 0;
  int mem_wr_n = 0, ep_wr_n = 0, ep_rd_n = 0, done_n = 0, cyc_n = 0, bus_err = 0;
  logic          pl_mem_we = 1'b0, pl_ep_we = 1'b0;
  logic [MW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  always @(posedge clk) begin
    if (pl_mem_we) mem_arr[pl_addr] <= pl_data;
    if (rst) begin
      mem_ack <= 1'b0; mem_wait <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0; mem_wait <= 0;
    end else if (mem_cyc) begin
      if (mem_wait >= mem_dly) begin
        mem_ack <= 1'b1;
        if (mem_we) begin
          mem_arr[mem_addr] <= mem_wdata;
          mem_wr_n <= mem_wr_n + 1;
        end
      end else mem_wait <= mem_wait + 1;
    end else mem_wait <= 0;
  end

  always @(posedge clk) begin
    if (pl_ep_we) ep_arr[pl_addr[EW-1:0]] <= pl_data;
    if (rst) begin
      ep_ack <= 1'b0; ep_wait <= 0;
    end else if (ep_ack) begin
      ep_ack <= 1'b0; ep_wait <= 0;
    end else if (ep_cyc) begin
      if (ep_wait >= ep_dly) begin
        ep_ack <= 1'b1;
        if (ep_we) begin
          ep_arr[ep_addr] <= ep_wdata;
          ep_wr_n <= ep_wr_n + 1;
        end else begin
          ep_rd_log[ep_rd_n % 4096] <= ep_addr;
          ep_rd_n <= ep_rd_n + 1;
        end
      end else ep_wait <= ep_wait + 1;
    end else ep_wait <= 0;
  end

  assign mem_rdata = mem_ack ? mem_arr[mem_addr] : 32'h0;
  assign ep_rdata  = ep_ack ? ep_arr[ep_addr] : 32'h0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (done_stb) done_n <= done_n + 1;
  end

  // Master must hold cyc, address, we and write data until it sees an ack.
  logic          p_rst = 1'b1, p_mcyc = 1'b0, p_mack = 1'b0, p_mwe = 1'b0;
  logic          p_ecyc = 1'b0, p_eack = 1'b0, p_ewe = 1'b0;
  logic [MW-1:0] p_maddr = '0;
  logic [EW-1:0] p_eaddr = '0;
  logic [31:0]   p_mwd = '0, p_ewd = '0;
  always @(posedge clk) begin
    if (!p_rst && p_mcyc && !p_mack &&
        (!mem_cyc || mem_addr != p_maddr || mem_we != p_mwe || (p_mwe && mem_wdata != p_mwd)))
      bus_err <= bus_err + 1;
    if (!p_rst && p_ecyc && !p_eack &&
        (!ep_cyc || ep_addr != p_eaddr || ep_we != p_ewe || (p_ewe && ep_wdata != p_ewd)))
      bus_err <= bus_err + 1;
    p_rst <= rst; p_mcyc <= mem_cyc; p_mack <= mem_ack; p_mwe <= mem_we;
    p_maddr <= mem_addr; p_mwd <= mem_wdata;
    p_ecyc <= ep_cyc; p_eack <= ep_ack; p_ewe <= ep_we;
    p_eaddr <= ep_addr; p_ewd <= ep_wdata;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_cyc = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    @(posedge clk); @(posedge clk); #1;
    csr_cyc = 1'b0; csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_cyc = 1'b1; csr_we = 1'b0; csr_addr = a;
    @(posedge clk); @(negedge clk);
    d = csr_ack ? csr_rdata : 32'hDEAD_0ACC;
    @(posedge clk); #1;
    csr_cyc = 1'b0;
  endtask

  task automatic pl_mem(input int a, input logic [31:0] d);
    mdl_mem[a] = d; pl_addr = MW'(a); pl_data = d; pl_mem_we = 1'b1;
    @(posedge clk); #1 pl_mem_we = 1'b0;
  endtask

  task automatic pl_ep(input int a, input logic [31:0] d);
    mdl_ep[a] = d; pl_addr = MW'(a); pl_data = d; pl_ep_we = 1'b1;
    @(posedge clk); #1 pl_ep_we = 1'b0;
  endtask

  // Returns the 1-based cycle (relative to the cycle holding t0) in which done_stb is seen.
  task automatic wait_done(input int t0, input int maxc, output int k);
    k = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done_stb) begin
        k = cyc_n - t0 + 1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic xfer(input string nm, input bit dir, input int e, input int m, input int len,
                      input int dm, input int de, input bit fill, input bit meddle);
    int n, w0, d0, k, t0, bad;
    logic [31:0] r;
    n = len + 1;
    mem_dly = dm; ep_dly = de;
    if (fill)
      for (int i = 0; i < n; i++)
        if (dir) pl_ep((e + i) % EN, $urandom);
        else     pl_mem((m + i) % MN, $urandom);
    csr_wr(2'd1, 32'(e));
    csr_wr(2'd2, 32'(m));
    w0 = dir ? mem_wr_n : ep_wr_n;
    d0 = done_n;
    csr_wr(2'd0, 32'h8000 | (32'(dir) << 14) | 32'(len));
    t0 = cyc_n;
    csr_rd(2'd0, r);
    chk({nm, " stat busy"}, r, 32'h8000_0000 | (32'(dir) << 14) | 32'(n));
    if (meddle) begin
      csr_wr(2'd1, 32'h055);
      csr_wr(2'd2, 32'h1234);
      csr_wr(2'd0, 32'h8000 | 32'h4000 | 32'd2);
    end
    wait_done(t0, n * (4 + dm + de) + 100, k);
    chk({nm, " done cycle"}, k, n * (4 + dm + de));
    chk({nm, " done pulses"}, done_n - d0, 1);
    chk({nm, " write count"}, (dir ? mem_wr_n : ep_wr_n) - w0, n);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (dir) begin
        mdl_mem[(m + i) % MN] = mdl_ep[(e + i) % EN];
        if (mem_arr[(m + i) % MN] !== mdl_mem[(m + i) % MN]) bad++;
      end else begin
        mdl_ep[(e + i) % EN] = mdl_mem[(m + i) % MN];
        if (ep_arr[(e + i) % EN] !== mdl_ep[(e + i) % EN]) bad++;
      end
    end
    chk({nm, " bad words"}, bad, 0);
    csr_rd(2'd0, r);
    chk({nm, " stat end"}, r, 32'h4000_0000 | (32'(dir) << 14));
    csr_rd(2'd1, r);
    chk({nm, " ep_addr end"}, r, 32'((e + n) % EN));
    csr_rd(2'd2, r);
    chk({nm, " mem_addr end"}, r, 32'((m + n) % MN));
    mem_dly = 0; ep_dly = 0;
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[14];
    logic [31:0] r;
    int w0, d0, k, rd0, bad;

    tbl[0]  = '{0, 2'd0, 32'h0,         32'h0};
    tbl[1]  = '{0, 2'd1, 32'h0,         32'h0};
    tbl[2]  = '{0, 2'd2, 32'h0,         32'h0};
    tbl[3]  = '{0, 2'd3, 32'h0,         32'h0};
    tbl[4]  = '{1, 2'd1, 32'hFFFF_FFFF, 32'h0};
    tbl[5]  = '{0, 2'd1, 32'h0,         32'h1FF};
    tbl[6]  = '{1, 2'd2, 32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{0, 2'd2, 32'h0,         32'h7FFF};
    tbl[8]  = '{1, 2'd3, 32'h1234_5678, 32'h0};
    tbl[9]  = '{0, 2'd3, 32'h0,         32'h0};
    tbl[10] = '{1, 2'd0, 32'h0000_2000, 32'h0};
    tbl[11] = '{0, 2'd0, 32'h0,         32'h0};
    tbl[12] = '{1, 2'd1, 32'h0000_00AB, 32'h0};
    tbl[13] = '{0, 2'd1, 32'h0,         32'hAB};

    rst = 1'b1; csr_cyc = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset strobes", {26'b0, ep_cyc, ep_we, mem_cyc, mem_we, csr_ack, done_stb}, 32'h0);
    chk("reset rdata", csr_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].we) csr_wr(tbl[i].a, tbl[i].d);
      else begin
        csr_rd(tbl[i].a, r);
        chk($sformatf("csr vec %0d", i), r, tbl[i].exp);
      end
    end

    // Basic mem -> ep copy with known data.
    for (int i = 0; i < 4; i++) pl_mem('h100 + i, 32'hA000_0000 + 32'(i));
    xfer("t1", 1'b0, 'h010, 'h0100, 3, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1 ep word %0d", i), ep_arr['h10 + i], 32'hA000_0000 + 32'(i));

    // ep -> mem with EP address wrap.
    rd0 = ep_rd_n;
    xfer("t2", 1'b1, 'h1FE, 'h0200, 3, 0, 0, 1'b1, 1'b0);
    chk("t2 rd addr 0", 32'(ep_rd_log[(rd0 + 0) % 4096]), 32'h1FE);
    chk("t2 rd addr 1", 32'(ep_rd_log[(rd0 + 1) % 4096]), 32'h1FF);
    chk("t2 rd addr 2", 32'(ep_rd_log[(rd0 + 2) % 4096]), 32'h000);
    chk("t2 rd addr 3", 32'(ep_rd_log[(rd0 + 3) % 4096]), 32'h001);

    // Slow memory as destination.
    xfer("t3", 1'b1, 'h100, 'h0600, 1, 3, 0, 1'b1, 1'b0);
    chk("t3 bus hold", bus_err, 0);

    // Abort after the second word lands: exactly three words move.
    for (int i = 0; i < 16; i++) pl_mem('h300 + i, $urandom);
    csr_wr(2'd1, 32'h40);
    csr_wr(2'd2, 32'h300);
    w0 = ep_wr_n; d0 = done_n;
    csr_wr(2'd0, 32'h800F);
    for (int i = 0; i < 200 && (ep_wr_n - w0) < 2; i++) @(negedge clk);
    chk("t4 abort sync", ep_wr_n - w0, 2);
    csr_wr(2'd0, 32'h2000);
    wait_done(cyc_n, 200, k);
    chk("t4 done seen", 32'(k > 0), 1);
    chk("t4 words", ep_wr_n - w0, 3);
    chk("t4 done pulses", done_n - d0, 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      mdl_ep['h40 + i] = mdl_mem['h300 + i];
      if (ep_arr['h40 + i] !== mdl_ep['h40 + i]) bad++;
    end
    chk("t4 bad words", bad, 0);
    csr_rd(2'd0, r); chk("t4 stat", r, 32'h6000_0000);
    csr_rd(2'd1, r); chk("t4 ep_addr", r, 32'h43);
    csr_rd(2'd2, r); chk("t4 mem_addr", r, 32'h303);
    csr_wr(2'd0, 32'h2000);
    csr_rd(2'd0, r); chk("t4 idle abort", r, 32'h6000_0000);

    // Writes while busy are ignored; a fresh start clears done/aborted.
    xfer("t5", 1'b0, 'h080, 'h0400, 7, 0, 0, 1'b1, 1'b1);

    // Reset during the write of word 1.
    for (int i = 0; i < 4; i++) pl_mem('h500 + i, $urandom);
    csr_wr(2'd1, 32'h20);
    csr_wr(2'd2, 32'h500);
    d0 = done_n;
    csr_wr(2'd0, 32'h8003);
    repeat (7) @(negedge clk);
    chk("t6 in write", {30'b0, ep_cyc, ep_we}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 cyc drop", {30'b0, ep_cyc, mem_cyc}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6 no done", done_n - d0, 0);
    csr_rd(2'd0, r); chk("t6 stat", r, 32'h0);
    csr_rd(2'd1, r); chk("t6 ep_addr", r, 32'h0);
    xfer("t6 fresh", 1'b0, 'h020, 'h0500, 3, 0, 0, 1'b1, 1'b0);

    // Maximum length: 2^LW words.
    xfer("max len", 1'b0, 'h000, 'h1000, (1 << LW) - 1, 0, 0, 1'b1, 1'b0);

    for (int it = 0; it < 12; it++) begin
      int len;
      len = (it % 4 == 3) ? int'($urandom_range(8, 40)) : int'($urandom_range(0, 7));
      xfer($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)), int'($urandom_range(0, EN - 1)),
           int'($urandom_range(0, MN - 1)), len, int'($urandom_range(0, 2)),
           int'($urandom_range(0, 2)), 1'b1, 1'b0);
    end

    chk("bus hold overall", bus_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
